// File: rtl/mdu_iter_pkg.sv
// Shared types, encodings and helpers for the iterative multiply/divide unit.
package mdu_iter_pkg;

  typedef logic        i1;
  typedef logic [1:0]  i2;
  typedef logic [31:0] i32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } ctrl_mdu_op_t;

  typedef struct packed {
    ctrl_mdu_op_t op;
    i32           a;
    i32           b;
  } mdu_req_t;

  localparam logic [1:0] MDU_STATE_IDLE = 2'd0;
  localparam logic [1:0] MDU_STATE_MUL  = 2'd1;
  localparam logic [1:0] MDU_STATE_DIV  = 2'd2;
  localparam logic [1:0] MDU_STATE_DONE = 2'd3;

  localparam int unsigned DIV_STEPS = 32;
  localparam int unsigned CNT_W     = 5;

  // Magnitude of x when it is to be treated as a signed value.
  function automatic i32 mag32(input i32 x, input i1 sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

  function automatic i32 neg_if(input i32 x, input i1 neg);
    return neg ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// E-stage request/response bundle between the pipeline and the MDU.
interface mdu_iter_if;
  import mdu_iter_pkg::*;

  logic         valid_in;
  ctrl_mdu_op_t op;
  i32           src_a;
  i32           src_b;
  logic         flush;
  logic         stall;
  logic         busy;
  logic         done;
  i32           hi;
  i32           lo;
  i2            hilo_write_en;

  modport master (
    output valid_in, op, src_a, src_b, flush,
    input  stall, busy, done, hi, lo, hilo_write_en
  );

  modport slave (
    input  valid_in, op, src_a, src_b, flush,
    output stall, busy, done, hi, lo, hilo_write_en
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring division step: shift in the next dividend bit, subtract if it fits.
module mdu_div_step
  import mdu_iter_pkg::*;
(
  input  i32 i_rem,
  input  i32 i_quo,
  input  i32 i_divisor,
  output i32 o_rem_c,
  output i32 o_quo_c
);
  logic [32:0] w_shift;
  logic [33:0] w_trial;

  // Partial remainder can reach 33 bits, so the trial subtract is 34 bits wide.
  always_comb begin
    w_shift = {i_rem, i_quo[31]};
    w_trial = {1'b0, w_shift} - {2'b00, i_divisor};
    if (w_trial[33]) begin
      o_rem_c = w_shift[31:0];
      o_quo_c = {i_quo[30:0], 1'b0};
    end else begin
      o_rem_c = w_trial[31:0];
      o_quo_c = {i_quo[30:0], 1'b1};
    end
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit: stalls E while busy, returns {hi,lo} with a one-cycle done.
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 4
) (
  input logic       clk,
  input logic       reset,
  mdu_iter_if.slave bus
);
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic             w_accept;
  logic             w_is_div;
  logic             w_sx;
  logic             w_mul_sx;
  logic [CNT_W-1:0] r_cnt;
  mdu_req_t         r_req;
  i32               r_rem;
  i32               r_quo;
  i32               r_divisor;
  i1                r_neg_q;
  i1                r_neg_r;
  logic             r_done;
  logic             r_busy;
  i32               r_hi;
  i32               r_lo;
  i32               w_rem_nxt;
  i32               w_quo_nxt;
  logic [63:0]      w_a64;
  logic [63:0]      w_b64;
  logic [63:0]      w_prod;

  assign w_is_div = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
  assign w_sx     = (bus.op == MDU_DIV);

  mdu_div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_divisor),
    .o_rem_c   (w_rem_nxt),
    .o_quo_c   (w_quo_nxt)
  );

  // Extending both operands to 64 bits lets one unsigned multiply serve MULT and MULTU.
  assign w_mul_sx = (r_req.op == MDU_MULT);
  assign w_a64    = {{32{w_mul_sx & r_req.a[31]}}, r_req.a};
  assign w_b64    = {{32{w_mul_sx & r_req.b[31]}}, r_req.b};
  assign w_prod   = w_a64 * w_b64;

  always_ff @(posedge clk) begin
    if (reset) r_state <= MDU_STATE_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      MDU_STATE_IDLE: begin
        if (bus.valid_in) begin
          w_accept = 1'b1;
          w_next   = w_is_div ? MDU_STATE_DIV : MDU_STATE_MUL;
        end
      end
      MDU_STATE_MUL:  if (r_cnt == '0) w_next = MDU_STATE_DONE;
      MDU_STATE_DIV:  if (r_cnt == '0) w_next = MDU_STATE_DONE;
      MDU_STATE_DONE: w_next = MDU_STATE_IDLE;
      default:        w_next = MDU_STATE_IDLE;
    endcase
    if (bus.flush) begin
      w_next   = MDU_STATE_IDLE;
      w_accept = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_req     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= (w_next == MDU_STATE_DONE);
      r_busy <= (w_next == MDU_STATE_MUL) || (w_next == MDU_STATE_DIV);
      if (w_accept) begin
        r_req     <= '{op: bus.op, a: bus.src_a, b: bus.src_b};
        r_cnt     <= w_is_div ? CNT_W'(DIV_STEPS - 1) : CNT_W'(MUL_CYCLES - 1);
        r_rem     <= '0;
        r_quo     <= mag32(bus.src_a, w_sx);
        r_divisor <= mag32(bus.src_b, w_sx);
        r_neg_q   <= w_sx & (bus.src_a[31] ^ bus.src_b[31]);
        r_neg_r   <= w_sx & bus.src_a[31];
      end else if ((r_state == MDU_STATE_MUL) || (r_state == MDU_STATE_DIV)) begin
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        if (r_state == MDU_STATE_DIV) begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
        end
      end
      // Results land only on entry to DONE; otherwise hi/lo hold.
      if (w_next == MDU_STATE_DONE) begin
        if (r_state == MDU_STATE_MUL) begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end else begin
          r_hi <= neg_if(w_rem_nxt, r_neg_r);
          r_lo <= neg_if(w_quo_nxt, r_neg_q);
        end
      end
    end
  end

  assign bus.stall         = bus.valid_in & ~r_done;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.hi            = r_hi;
  assign bus.lo            = r_lo;
  assign bus.hilo_write_en = {r_done, r_done};
endmodule
